pipe_core: RTL and testbench

PIPE_CORE -- requirements
Module: pipe_core

---
 rtl/pipe_core.sv | 126 ++++++++++++
 tb/tb_pipe_core.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_core.sv
// rtl/pipe_core.sv - single-issue RV32I ALU core with one writeback stage
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   instr_valid, instr, instr_ready instruction handshake (ready is combinational)
//   result_valid, result_ready      retiring-result handshake
//   alu_result, result_rd, illegal  registered writeback stage contents
//   retired                         wrapping count of retired instructions
module pipe_core #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    input  logic [31:0]      instr,
    output logic             instr_ready,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [XLEN-1:0]  alu_result,
    output logic [4:0]       result_rd,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);
    localparam int SW  = $clog2(XLEN);
    localparam int RIW = $clog2(NREG);
    localparam logic [5:0] NREG_L = 6'(NREG);

    logic [XLEN-1:0] regs [NREG];

    logic [6:0] opcode, f7;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign f3     = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign f7     = instr[31:25];

    logic accept, retire;
    assign instr_ready = !result_valid || result_ready;
    assign accept      = instr_valid && instr_ready;
    assign retire      = result_valid && result_ready;

    logic            is_r, is_i, r_ok, i_ok, shift_hi_ok, idx_ok, illegal_d;
    logic [XLEN-1:0] rs1_val, rs2_val, op_b, imm, res, alu_d;
    logic [SW-1:0]   shamt;
    logic            fwd_ok;

    assign is_r = (opcode == 7'b0110011);
    assign is_i = (opcode == 7'b0010011);
    assign imm  = {{(XLEN-12){instr[31]}}, instr[31:20]};

    // Only a WB entry that will actually be written may be forwarded.
    assign fwd_ok = result_valid && !illegal && (result_rd != 5'd0);

    always_comb begin
        // Shift immediates: the bits above the shift amount must be zero,
        // except bit 30 which selects arithmetic right shift. On XLEN=64
        // instr[25] is part of the 6-bit shift amount.
        shift_hi_ok = !instr[31] && (instr[29:26] == 4'd0) && (SW == 6 || !instr[25]);
        r_ok = (f7 == 7'd0) || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
        case (f3)
            3'b001:  i_ok = shift_hi_ok && !instr[30];
            3'b101:  i_ok = shift_hi_ok;
            default: i_ok = 1'b1;
        endcase
        idx_ok = ({1'b0, rd} < NREG_L) && ({1'b0, rs1} < NREG_L) &&
                 (!is_r || ({1'b0, rs2} < NREG_L));
        illegal_d = !((is_r && r_ok) || (is_i && i_ok)) || !idx_ok;
    end

    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (rs1 != 5'd0 && {1'b0, rs1} < NREG_L) rs1_val = regs[rs1[RIW-1:0]];
        if (rs2 != 5'd0 && {1'b0, rs2} < NREG_L) rs2_val = regs[rs2[RIW-1:0]];
        if (fwd_ok && result_rd == rs1) rs1_val = alu_result;
        if (fwd_ok && result_rd == rs2) rs2_val = alu_result;
    end

    assign op_b  = is_r ? rs2_val : imm;
    assign shamt = op_b[SW-1:0];

    always_comb begin
        res = '0;
        case (f3)
            3'b000:  res = (is_r && instr[30]) ? rs1_val - op_b : rs1_val + op_b;
            3'b001:  res = rs1_val << shamt;
            3'b010:  res[0] = ($signed(rs1_val) < $signed(op_b));
            3'b011:  res[0] = (rs1_val < op_b);
            3'b100:  res = rs1_val ^ op_b;
            3'b101:  res = instr[30] ? XLEN'($signed(rs1_val) >>> shamt) : rs1_val >> shamt;
            3'b110:  res = rs1_val | op_b;
            default: res = rs1_val & op_b;
        endcase
        alu_d = illegal_d ? '0 : res;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regs         <= '{default: '0};
            result_valid <= 1'b0;
            alu_result   <= '0;
            result_rd    <= '0;
            illegal      <= 1'b0;
            retired      <= '0;
        end else begin
            if (retire) begin
                retired <= retired + 1'b1;
                if (!illegal && result_rd != 5'd0)
                    regs[result_rd[RIW-1:0]] <= alu_result;
            end
            if (accept) begin
                result_valid <= 1'b1;
                alu_result   <= alu_d;
                result_rd    <= rd;
                illegal      <= illegal_d;
            end else if (retire) begin
                result_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pipe_core.sv
// tb/tb_pipe_core.sv - directed testbench for pipe_core
module tb_pipe_core;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid = 1'b0;
    logic [31:0] instr = 32'd0;
    logic        result_ready = 1'b1;

    logic        a_ready, a_valid, a_ill;
    logic [31:0] a_alu, a_ret;
    logic [4:0]  a_rd;
    logic        b_ready, b_valid, b_ill;
    logic [31:0] b_alu, b_ret;
    logic [4:0]  b_rd;
    logic        c_ready, c_valid, c_ill;
    logic [63:0] c_alu;
    logic [31:0] c_ret;
    logic [4:0]  c_rd;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pipe_core #(.XLEN(32), .NREG(32), .CNT_W(32)) dut_a (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(a_ready), .result_valid(a_valid), .result_ready(result_ready),
        .alu_result(a_alu), .result_rd(a_rd), .illegal(a_ill), .retired(a_ret));

    pipe_core #(.XLEN(32), .NREG(16), .CNT_W(32)) dut_b (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(b_ready), .result_valid(b_valid), .result_ready(result_ready),
        .alu_result(b_alu), .result_rd(b_rd), .illegal(b_ill), .retired(b_ret));

    pipe_core #(.XLEN(64), .NREG(32), .CNT_W(32)) dut_c (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(c_ready), .result_valid(c_valid), .result_ready(result_ready),
        .alu_result(c_alu), .result_rd(c_rd), .illegal(c_ill), .retired(c_ret));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    // Present one instruction for a single cycle; returns at the negedge after
    // the accept edge, with the result sitting in the WB stage.
    task automatic send(input logic [31:0] w);
        @(negedge clk);
        instr = w;
        instr_valid = 1'b1;
        check("send_ready", {63'd0, a_ready}, 64'd1);
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_valid", {63'd0, a_valid}, 64'd0);
        check("rst_alu", {32'd0, a_alu}, 64'd0);
        check("rst_ret", {32'd0, a_ret}, 64'd0);
        check("rst_rd", {59'd0, a_rd}, 64'd0);
        reset = 1'b0;

        // Back-to-back with forwarding of x1
        @(negedge clk);
        instr = enc_i(3'b000, 5'd1, 5'd0, 12'd5);
        instr_valid = 1'b1;
        @(negedge clk);
        check("addi_5", {32'd0, a_alu}, 64'd5);
        check("addi_5_vld", {63'd0, a_valid}, 64'd1);
        instr = enc_i(3'b000, 5'd2, 5'd1, 12'hFF9);
        @(negedge clk);
        instr_valid = 1'b0;
        check("addi_byp", {32'd0, a_alu}, 64'hFFFF_FFFE);
        check("addi_byp_rd", {59'd0, a_rd}, 64'd2);
        @(negedge clk);
        check("ret_2", {32'd0, a_ret}, 64'd2);
        check("idle_valid", {63'd0, a_valid}, 64'd0);

        // Shifts and compares on x1 = 0x80000000
        send(enc_i(3'b000, 5'd1, 5'd0, 12'd1));
        send(enc_i(3'b001, 5'd1, 5'd1, 12'h01F));
        check("slli_31", {32'd0, a_alu}, 64'h8000_0000);
        send(enc_i(3'b101, 5'd3, 5'd1, 12'h404));
        check("srai", {32'd0, a_alu}, 64'hF800_0000);
        send(enc_i(3'b101, 5'd3, 5'd1, 12'h004));
        check("srli", {32'd0, a_alu}, 64'h0800_0000);
        send(enc_r(7'd0, 3'b010, 5'd4, 5'd1, 5'd0));
        check("slt", {32'd0, a_alu}, 64'd1);
        send(enc_r(7'd0, 3'b011, 5'd4, 5'd1, 5'd0));
        check("sltu", {32'd0, a_alu}, 64'd0);
        send(enc_r(7'b0100000, 3'b000, 5'd6, 5'd0, 5'd1));
        check("sub_wrap", {32'd0, a_alu}, 64'h8000_0000);
        @(negedge clk);

        // Stall: ADD x5,x1,x2 = 0x80000000 + 0xFFFFFFFE
        result_ready = 1'b0;
        send(enc_r(7'd0, 3'b000, 5'd5, 5'd1, 5'd2));
        for (int i = 0; i < 3; i++) begin
            check("stall_alu", {32'd0, a_alu}, 64'h7FFF_FFFE);
            check("stall_valid", {63'd0, a_valid}, 64'd1);
            check("stall_ready", {63'd0, a_ready}, 64'd0);
            check("stall_ret", {32'd0, a_ret}, 64'd9);
            @(negedge clk);
        end
        result_ready = 1'b1;
        @(negedge clk);
        check("release_ret", {32'd0, a_ret}, 64'd10);
        check("release_valid", {63'd0, a_valid}, 64'd0);
        send(enc_r(7'd0, 3'b000, 5'd7, 5'd5, 5'd0));
        check("read_x5", {32'd0, a_alu}, 64'h7FFF_FFFE);

        // x0 writes discarded, and x0 is never forwarded
        @(negedge clk);
        instr = enc_i(3'b000, 5'd0, 5'd0, 12'd9);
        instr_valid = 1'b1;
        @(negedge clk);
        check("addi_x0", {32'd0, a_alu}, 64'd9);
        instr = enc_r(7'd0, 3'b000, 5'd5, 5'd0, 5'd0);
        @(negedge clk);
        instr_valid = 1'b0;
        check("x0_reads_0", {32'd0, a_alu}, 64'd0);

        send(32'h0000_0073);
        check("ecall_ill", {63'd0, a_ill}, 64'd1);
        check("ecall_alu", {32'd0, a_alu}, 64'd0);
        send(enc_r(7'd0, 3'b000, 5'd8, 5'd1, 5'd0));
        check("x1_kept", {32'd0, a_alu}, 64'h8000_0000);
        check("ecall_counted", {32'd0, a_ret}, 64'd14);
        send(enc_r(7'b0100000, 3'b001, 5'd9, 5'd1, 5'd1));
        check("bad_f7_ill", {63'd0, a_ill}, 64'd1);
        check("bad_f7_ret", {32'd0, a_ret}, 64'd15);

        // Parameter corners
        send(enc_i(3'b000, 5'd20, 5'd0, 12'd1));
        check("nreg16_ill", {63'd0, b_ill}, 64'd1);
        check("nreg16_alu", {32'd0, b_alu}, 64'd0);
        check("nreg32_ok", {63'd0, a_ill}, 64'd0);
        check("nreg32_alu", {32'd0, a_alu}, 64'd1);
        send(enc_i(3'b000, 5'd1, 5'd0, 12'd1));
        send(enc_i(3'b001, 5'd1, 5'd1, 12'h028));
        check("x64_slli40", c_alu, 64'h0000_0100_0000_0000);
        check("x64_slli_ok", {63'd0, c_ill}, 64'd0);
        check("x32_slli40_ill", {63'd0, a_ill}, 64'd1);
        @(negedge clk);

        // Reset while stalled, with a competing accept
        result_ready = 1'b0;
        send(enc_i(3'b000, 5'd9, 5'd0, 12'd3));
        check("pre_rst_valid", {63'd0, a_valid}, 64'd1);
        check("pre_rst_alu", {32'd0, a_alu}, 64'd3);
        reset = 1'b1;
        instr = enc_i(3'b000, 5'd11, 5'd0, 12'd7);
        instr_valid = 1'b1;
        @(negedge clk);
        check("rst2_valid", {63'd0, a_valid}, 64'd0);
        check("rst2_ret", {32'd0, a_ret}, 64'd0);
        check("rst2_alu", {32'd0, a_alu}, 64'd0);
        reset = 1'b0;
        instr_valid = 1'b0;
        result_ready = 1'b1;
        send(enc_r(7'd0, 3'b000, 5'd10, 5'd9, 5'd0));
        check("x9_cleared", {32'd0, a_alu}, 64'd0);
        send(enc_r(7'd0, 3'b000, 5'd12, 5'd1, 5'd0));
        check("x1_cleared", {32'd0, a_alu}, 64'd0);
        @(negedge clk);
        check("post_rst_ret", {32'd0, a_ret}, 64'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
